// File: rtl/char_grid_writer.sv
// Character grid writer: turns a strobed byte stream into writes on a ROWS x COLS
// character grid, with cursor tracking, clear sweeps and a registered read port.
module char_grid_writer #(
    parameter int unsigned COLS       = 16,
    parameter int unsigned ROWS       = 4,
    parameter logic [7:0]  FILL_CHAR  = 8'h20,
    parameter logic [7:0]  SUBST_CHAR = 8'h3F,
    localparam int unsigned COL_W     = $clog2(COLS),
    localparam int unsigned ROW_W     = $clog2(ROWS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             inByte,
    output logic                   busy,
    output logic                   dropped,
    output logic [ROW_W-1:0]       cursorRow,
    output logic [COL_W-1:0]       cursorCol,
    input  logic [ROW_W+COL_W-1:0] readAddress,
    output logic [7:0]             readByte
);

    localparam int unsigned ADDR_W = ROW_W + COL_W;
    localparam int unsigned DEPTH  = ROWS * COLS;

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    typedef enum logic [1:0] {
        S_CLEAR_ALL,
        S_IDLE,
        S_CLEAR_ROW
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_addr;

    logic [7:0]        grid [DEPTH];

    logic              in_valid;
    logic              is_print;
    logic              is_subst;
    logic              col_last;
    logic [ROW_W-1:0]  row_next;
    logic [COL_W-1:0]  col_dec;
    logic              clr_done;

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [7:0]        wdata;

    always_comb begin
        in_valid = (inByte != 8'h00);
        is_print = (inByte >= 8'h20) && (inByte <= 8'h7E);
        is_subst = in_valid && !is_print &&
                   (inByte != CH_BS) && (inByte != CH_LF) &&
                   (inByte != CH_FF) && (inByte != CH_CR);
        col_last = (cursorCol == COL_W'(COLS - 1));
        row_next = cursorRow + 1'b1;
        col_dec  = cursorCol - 1'b1;
        clr_done = (state == S_CLEAR_ALL) ? (clr_addr == '1)
                                          : (clr_addr[COL_W-1:0] == '1);
    end

    // Single write port: the sweep owns it while busy, the byte decoder otherwise.
    always_comb begin
        we    = 1'b0;
        waddr = {cursorRow, cursorCol};
        wdata = FILL_CHAR;
        if (!reset) begin
            if (state != S_IDLE) begin
                we    = 1'b1;
                waddr = clr_addr;
                wdata = FILL_CHAR;
            end else if (is_print) begin
                we    = 1'b1;
                wdata = inByte;
            end else if (is_subst) begin
                we    = 1'b1;
                wdata = SUBST_CHAR;
            end else if (inByte == CH_BS && cursorCol != '0) begin
                we    = 1'b1;
                waddr = {cursorRow, col_dec};
                wdata = FILL_CHAR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_CLEAR_ALL;
            clr_addr  <= '0;
            busy      <= 1'b1;
            dropped   <= 1'b0;
            cursorRow <= '0;
            cursorCol <= '0;
        end else begin
            case (state)
                S_CLEAR_ALL, S_CLEAR_ROW: begin
                    if (in_valid) begin
                        dropped <= 1'b1;
                    end
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_done) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (is_print || is_subst) begin
                        if (col_last) begin
                            cursorCol <= '0;
                            cursorRow <= row_next;
                            clr_addr  <= {row_next, {COL_W{1'b0}}};
                            state     <= S_CLEAR_ROW;
                            busy      <= 1'b1;
                        end else begin
                            cursorCol <= cursorCol + 1'b1;
                        end
                    end else begin
                        case (inByte)
                            CH_CR: cursorCol <= '0;
                            CH_LF: begin
                                cursorCol <= '0;
                                cursorRow <= row_next;
                                clr_addr  <= {row_next, {COL_W{1'b0}}};
                                state     <= S_CLEAR_ROW;
                                busy      <= 1'b1;
                            end
                            CH_BS: begin
                                if (cursorCol != '0) begin
                                    cursorCol <= col_dec;
                                end
                            end
                            CH_FF: begin
                                cursorCol <= '0;
                                cursorRow <= '0;
                                clr_addr  <= '0;
                                state     <= S_CLEAR_ALL;
                                busy      <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                default: begin
                    state    <= S_CLEAR_ALL;
                    clr_addr <= '0;
                    busy     <= 1'b1;
                end
            endcase
        end
    end

    // Read samples the array before this edge's write lands (read-before-write).
    always_ff @(posedge clk) begin
        if (we) begin
            grid[waddr] <= wdata;
        end
        if (reset) begin
            readByte <= '0;
        end else begin
            readByte <= grid[readAddress];
        end
    end

endmodule

// File: doc/char_grid_writer.md
Name: char_grid_writer

Overview:
- Downstream consumer of the typewriter character source.
- Accepts a strobed byte stream in which a non-zero byte means "character valid this cycle" and 0 means idle.
- Interprets printable bytes and a small control-code set, and maintains a cursor.
- Stores the result in a ROWS x COLS character grid; the text/font engine reads the grid through a registered read port addressed {row,col}.

Parameters:
- COLS, 16, characters per row; power of two; COL_W = log2(COLS).
- ROWS, 4, rows in grid; power of two; ROW_W = log2(ROWS).
- FILL_CHAR, 8'h20, byte written by every clear operation.
- SUBST_CHAR, 8'h3F, byte stored in place of unsupported codes.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- inByte  input  8  character stream; non-zero = one character this cycle; 0 = idle.
- busy  output  1  high while a clear sweep is running; inBytes are dropped.
- dropped  output  1  sticky; set when non-zero inByte arrives while busy; cleared only by reset.
- cursorRow  output  ROW_W  current cursor row.
- cursorCol  output  COL_W  current cursor column.
- readAddress  input  ROW_W+COL_W  read address {row,col}.
- readByte  output  8  grid content at readAddress, one-cycle latency.

Behaviour:
- Reset (sync, reset high on a posedge):
  - cursorRow=0, cursorCol=0, dropped=0, readByte=0.
  - FSM enters CLEAR_ALL; busy=1 from the first cycle after reset.
  - Reset asserted mid-sweep or mid-operation restarts CLEAR_ALL at address 0.
- FSM states: CLEAR_ALL, IDLE, CLEAR_ROW.
- CLEAR_ALL:
  - Writes FILL_CHAR to addresses 0..ROWS*COLS-1, one per cycle.
  - After the last write, moves to IDLE; busy falls on that same edge.
  - Total duration ROWS*COLS cycles (64 at defaults).
- IDLE, inByte processing (one byte per cycle, back-to-back non-zero bytes all honoured):
  - 0x20..0x7E: write byte at {cursorRow,cursorCol}, then advance.
  - 0x0D (CR): cursorCol=0; no write.
  - 0x0A (LF): cursorCol=0, row advance.
  - 0x08 (BS): if cursorCol>0, cursorCol-1 and write FILL_CHAR at the new position; at col 0, no action (no reverse row wrap).
  - 0x0C (FF): cursor to 0,0; enter CLEAR_ALL.
  - Any other non-zero byte: write SUBST_CHAR, then advance.
- Advance:
  - cursorCol+1.
  - At cursorCol==COLS-1: cursorCol=0 and row advance.
- Row advance:
  - cursorRow+1, wrapping ROWS-1 -> 0.
  - The newly entered row is always cleared: enter CLEAR_ROW, which writes FILL_CHAR to cols 0..COLS-1 of the new row (COLS cycles, busy=1), then returns to IDLE.
  - The character that triggered the advance is written before CLEAR_ROW starts.
- Busy handling:
  - Non-zero inByte while busy: discarded, dropped<=1, cursor unchanged.
  - The byte arriving on the cycle busy falls is also dropped; acceptance starts the cycle after busy is low.
- Cursor outputs are registered and reflect the post-update position one cycle after the accepting edge.
- Read port:
  - readByte <= grid[readAddress] every cycle, including while busy.
  - Same-cycle write and read to the same address returns the old value (read-before-write).
- Single write port; internal writes never collide (one source per cycle).

Test Plan:
- Reset, then wait 64 cycles -> busy high exactly 64 cycles; all 64 reads return 0x20; cursor 0,0; dropped=0.
- Feed "Hello World!" one byte per cycle with zeros between -> addresses 0..11 read "Hello World!"; cursor 0,12.
- 16 'A' back-to-back from 0,0 -> row 0 all 0x41; cursor 1,0; busy high 16 cycles; row 1 reads 0x20.
- Write 'x' at 3,15 -> wrap to row 0; row 0 cleared to 0x20; cursor 0,0. 'Z' during the sweep -> dropped=1, not stored.
- "AB", 0x08, 0x08, 0x08 -> addr0=0x20, addr1=0x20, cursor 0,0. Then 0x0D, 0x0A -> cursor 1,0. Then 0x01 -> addr16=0x3F.
- 0x0C mid-text -> 64-cycle clear, cursor 0,0. Reset pulse at sweep cycle 30 -> sweep restarts, busy for a further 64 cycles.
